// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame buffer between the audio sample source and the FFT engine.
// Two banks of FRAME_LEN samples alternate: one fills from the audio stream
// while the other is streamed out over a valid/ready interface. Samples that
// arrive while both banks are occupied are dropped and raise a sticky overflow.
module fft_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [7:0]        frame_count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              wr_bank
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic {
        W_FILL,
        W_WAIT
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_PRESENT
    } rd_state_t;

    // Both banks share one array; the bank number is the top address bit.
    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    wr_state_t         wr_state_reg, wr_state_next;
    logic              wr_bank_reg, wr_bank_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic              overflow_reg, overflow_next;
    logic [1:0]        full_reg, full_next;
    logic [1:0]        full_set, full_clr;
    logic              mem_we;

    rd_state_t         rd_state_reg, rd_state_next;
    logic              rd_bank_reg, rd_bank_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic [ADDR_W-1:0] out_index_reg, out_index_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_last_reg, out_last_next;
    logic [7:0]        frame_count_reg, frame_count_next;
    logic              rd_release;
    logic [DATA_W-1:0] mem_rd_data;

    // Sample storage: written by the fill side, no reset on contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{wr_bank_reg, wr_ptr_reg}] <= in_data;
        end
    end

    // Writer: fill the current bank, hand it over on the last sample, and
    // stall (dropping samples) when the next bank has not been read out yet.
    always_comb begin
        wr_state_next = wr_state_reg;
        wr_bank_next  = wr_bank_reg;
        wr_ptr_next   = wr_ptr_reg;
        overflow_next = overflow_reg;
        full_set      = 2'b00;
        mem_we        = 1'b0;
        // Clear first so a coincident drop below wins.
        if (clr_ovf) begin
            overflow_next = 1'b0;
        end
        case (wr_state_reg)
            W_FILL: begin
                if (!enable) begin
                    // Partial frame is abandoned; completed banks are kept.
                    wr_ptr_next = '0;
                end else if (in_valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr_reg == LAST_IDX) begin
                        full_set[wr_bank_reg] = 1'b1;
                        wr_ptr_next           = '0;
                        wr_bank_next          = !wr_bank_reg;
                        // A release of the other bank on this same edge
                        // frees it in time, so no stall is needed.
                        if (full_reg[!wr_bank_reg] &&
                            !(rd_release && (rd_bank_reg == !wr_bank_reg))) begin
                            wr_state_next = W_WAIT;
                        end
                    end else begin
                        wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
                    end
                end
            end
            W_WAIT: begin
                wr_ptr_next = '0;
                if (enable && in_valid) begin
                    overflow_next = 1'b1;
                end
                if (!full_reg[wr_bank_reg] ||
                    (rd_release && (rd_bank_reg == wr_bank_reg))) begin
                    wr_state_next = W_FILL;
                end
            end
            default: wr_state_next = W_FILL;
        endcase
    end

    // Reader: fetch one sample per word from the array into the output
    // register, hold it until the FFT accepts, release the bank after the last.
    always_comb begin
        rd_state_next    = rd_state_reg;
        rd_bank_next     = rd_bank_reg;
        rd_ptr_next      = rd_ptr_reg;
        out_data_next    = out_data_reg;
        out_index_next   = out_index_reg;
        out_valid_next   = out_valid_reg;
        out_last_next    = out_last_reg;
        frame_count_next = frame_count_reg;
        full_clr         = 2'b00;
        rd_release       = 1'b0;
        mem_rd_data      = mem[{rd_bank_reg, rd_ptr_reg}];
        case (rd_state_reg)
            R_IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    rd_ptr_next   = '0;
                    rd_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                out_data_next  = mem_rd_data;
                out_index_next = rd_ptr_reg;
                out_last_next  = (rd_ptr_reg == LAST_IDX);
                out_valid_next = 1'b1;
                rd_state_next  = R_PRESENT;
            end
            R_PRESENT: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    if (out_last_reg) begin
                        rd_release            = 1'b1;
                        full_clr[rd_bank_reg] = 1'b1;
                        rd_bank_next          = !rd_bank_reg;
                        frame_count_next      = frame_count_reg + 8'd1;
                        rd_state_next         = R_IDLE;
                    end else begin
                        rd_ptr_next   = rd_ptr_reg + ADDR_W'(1);
                        rd_state_next = R_FETCH;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Per-bank occupancy: the writer sets, the reader clears.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = full_set[gi] | (full_reg[gi] & ~full_clr[gi]);
        end
    endgenerate

    // State and output registers for both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg    <= W_FILL;
            wr_bank_reg     <= 1'b0;
            wr_ptr_reg      <= '0;
            overflow_reg    <= 1'b0;
            full_reg        <= 2'b00;
            rd_state_reg    <= R_IDLE;
            rd_bank_reg     <= 1'b0;
            rd_ptr_reg      <= '0;
            out_data_reg    <= '0;
            out_index_reg   <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            wr_state_reg    <= wr_state_next;
            wr_bank_reg     <= wr_bank_next;
            wr_ptr_reg      <= wr_ptr_next;
            overflow_reg    <= overflow_next;
            full_reg        <= full_next;
            rd_state_reg    <= rd_state_next;
            rd_bank_reg     <= rd_bank_next;
            rd_ptr_reg      <= rd_ptr_next;
            out_data_reg    <= out_data_next;
            out_index_reg   <= out_index_next;
            out_valid_reg   <= out_valid_next;
            out_last_reg    <= out_last_next;
            frame_count_reg <= frame_count_next;
        end
    end

    assign out_data    = out_data_reg;
    assign out_index   = out_index_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign frame_count = frame_count_reg;
    assign overflow    = overflow_reg;
    assign wr_bank     = wr_bank_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with 8-sample frames. Expected output
// words are queued as samples are driven and compared as the FFT side accepts.
module tb_fft_frame_ctrl;

    localparam int FL = 8;
    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          enable    = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_ovf   = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_valid;
    logic          out_last;
    logic [7:0]    frame_count;
    logic          overflow;
    logic          wr_bank;

    logic [AW+DW:0] sb [$];
    int n_cmp     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int last_xfer = -1;
    bit gap_chk   = 1'b0;

    fft_frame_ctrl #(
        .FRAME_LEN(FL),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_count(frame_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .wr_bank    (wr_bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW+DW:0] pack(input logic [DW-1:0] d, input int idx, input logic last);
        return {last, AW'(idx), d};
    endfunction

    // One clock: sample the stream at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [AW+DW:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check("stream", 32'({out_last, out_index, out_data}), 32'(exp));
                $display("xfer cyc=%0d data=%h idx=%0d last=%0d", cyc, out_data, out_index, out_last);
                if (gap_chk && last_xfer >= 0) begin
                    check("xfer_gap", 32'(cyc - last_xfer), 32'd2);
                end
                last_xfer = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit store, input int idx, input bit last);
        in_data  = d;
        in_valid = 1'b1;
        if (store) sb.push_back(pack(d, idx, last));
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit store);
        for (int i = 0; i < FL; i++) send(base + DW'(i), store, i, i == FL - 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Let the stream run until the given word is presented, then stall it there.
    task automatic run_until(input logic [DW-1:0] d, input string tag);
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (out_valid && out_data == d) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        out_ready = 1'b0;
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single frame, FFT always ready: latency and steady 2-cycle cadence
        out_ready = 1'b1;
        gap_chk   = 1'b1;
        for (int i = 0; i < FL - 1; i++) send(16'h1000 + DW'(i), 1'b1, i, 1'b0);
        in_data  = 16'h1007;
        in_valid = 1'b1;
        sb.push_back(pack(16'h1007, 7, 1'b1));
        tick();
        in_valid = 1'b0;
        check("lat_e0", 32'(out_valid), 32'd0);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd1);
        check("lat_first_data", 32'(out_data), 32'h1000);
        drain("t2_drain");
        gap_chk = 1'b0;
        check("t2_frame_count", 32'(frame_count), 32'd1);
        check("t2_wr_bank", 32'(wr_bank), 32'd1);

        // Backpressure while index 3 is presented
        out_ready = 1'b0;
        send_frame(16'h2000, 1'b1);
        run_until(16'h2003, "t3_reach_3");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data", 32'(out_data), 32'h2003);
            check("t3_hold_index", 32'(out_index), 32'd3);
            tick();
        end
        drain("t3_drain");
        check("t3_frame_count", 32'(frame_count), 32'd2);

        // Overflow: three frames with the FFT stalled
        out_ready = 1'b0;
        send_frame(16'h3000, 1'b1);
        send_frame(16'h3100, 1'b1);
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        send(16'h3200, 1'b0, 0, 1'b0);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        in_data  = 16'h3201;
        in_valid = 1'b1;
        clr_ovf  = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        check("t4_set_beats_clr", 32'(overflow), 32'd1);
        tick();
        for (int i = 2; i < FL; i++) send(16'h3200 + DW'(i), 1'b0, i, 1'b0);
        drain("t4_drain_ab");
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        check("t4_wr_bank", 32'(wr_bank), 32'd0);
        send_frame(16'h3300, 1'b1);
        drain("t4_drain_d");
        check("t4_frame_count", 32'(frame_count), 32'd5);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);

        // Bank 1 completes on the same edge bank 0 is released
        out_ready = 1'b0;
        send_frame(16'h4000, 1'b1);
        send_frame(16'h4100, 1'b1);
        run_until(16'h4107, "t5_reach_f7");
        check("t5_f7_last", 32'(out_last), 32'd1);
        check("t5_wr_bank_pre", 32'(wr_bank), 32'd1);
        for (int i = 0; i < FL - 1; i++) send(16'h4200 + DW'(i), 1'b1, i, 1'b0);
        in_data   = 16'h4207;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back(pack(16'h4207, 7, 1'b1));
        tick();
        in_valid = 1'b0;
        check("t5_no_ovf", 32'(overflow), 32'd0);
        check("t5_wr_bank", 32'(wr_bank), 32'd0);
        send_frame(16'h4300, 1'b1);
        check("t5_no_ovf_after", 32'(overflow), 32'd0);
        drain("t5_drain");
        check("t5_frame_count", 32'(frame_count), 32'd9);

        // Partial frame discarded when enable drops
        for (int i = 0; i < 3; i++) send(16'h5000 + DW'(i), 1'b0, i, 1'b0);
        enable = 1'b0;
        tick();
        send(16'h50ff, 1'b0, 0, 1'b0);
        enable = 1'b1;
        send_frame(16'h5100, 1'b1);
        drain("t6_drain");
        check("t6_frame_count", 32'(frame_count), 32'd10);
        check("t6_no_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset with a word on the stream
        out_ready = 1'b0;
        send_frame(16'h6000, 1'b0);
        send(16'h6100, 1'b0, 0, 1'b0);
        send(16'h6101, 1'b0, 1, 1'b0);
        check("t1_valid_before", 32'(out_valid), 32'd1);
        check("t1_wr_bank_before", 32'(wr_bank), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_async_valid", 32'(out_valid), 32'd0);
        check("t1_async_overflow", 32'(overflow), 32'd0);
        check("t1_async_frame_count", 32'(frame_count), 32'd0);
        check("t1_async_wr_bank", 32'(wr_bank), 32'd0);
        sb.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_frame(16'h7000, 1'b1);
        check("t1_first_bank0", 32'(wr_bank), 32'd1);
        drain("t1_drain");
        check("t1_frame_count", 32'(frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Ping-pong frame buffer controller between the audio sample source (16-bit samples with a 1-cycle data_valid strobe at 48 kHz) and the FFT engine. It collects FRAME_LEN consecutive samples into one of two internal banks. It then schedules frame readout to the FFT over a valid/ready stream while the other bank fills. It reports overflow when both banks are occupied.

Parameters:
FRAME_LEN, 64, samples per frame (power of 2, >= 4)
ADDR_W, 6, log2(FRAME_LEN)
DATA_W, 16, sample width

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  capture enable
in_data  in  DATA_W  sample from audio source
in_valid  in  1  1-cycle sample strobe
out_data  out  DATA_W  sample to FFT
out_index  out  ADDR_W  position of out_data within frame
out_valid  out  1  out_data valid
out_last  out  1  out_data is final sample of frame
out_ready  in  1  FFT accepts sample
frame_count  out  8  frames fully delivered, wraps 255->0
overflow  out  1  sticky: sample dropped
clr_ovf  in  1  clears overflow
wr_bank  out  1  bank currently filling

Behaviour:
- Reset is asynchronous and active-low on rst_n. All of the following are 0 in reset: out_data, out_index, out_valid, out_last, frame_count, overflow, wr_bank, both full flags, wr_ptr, rd_ptr, rd_bank. Memory contents are undefined.
- Storage: 2 x FRAME_LEN x DATA_W array. full[b] flag per bank.
- Writer FSM, states FILL and WAIT:
  - FILL: when enable && in_valid, write in_data to mem[wr_bank][wr_ptr] and increment wr_ptr.
  - When wr_ptr==FRAME_LEN-1 on a write: set full[wr_bank], clear wr_ptr, then:
    - if full[!wr_bank]==0, or the reader releases !wr_bank in the same cycle: wr_bank<=!wr_bank, stay in FILL;
    - otherwise go to WAIT with wr_bank<=!wr_bank.
  - WAIT: in_valid samples are dropped and overflow<=1. Return to FILL on the cycle full[wr_bank] clears. The first sample after that is written at index 0.
  - enable low: no writes; wr_ptr<=0, so a partial frame is discarded. Full banks are kept.
- Reader FSM, states IDLE, FETCH, PRESENT:
  - IDLE: if full[rd_bank], set rd_ptr<=0 and go to FETCH.
  - FETCH: out_data<=mem[rd_bank][rd_ptr], out_index<=rd_ptr, out_last<=(rd_ptr==FRAME_LEN-1), out_valid<=1, go to PRESENT.
  - PRESENT: hold out_data, out_index and out_last stable until out_valid && out_ready.
  - On transfer, out_valid<=0. If out_last: clear full[rd_bank], rd_bank<=!rd_bank, frame_count++, go to IDLE. Otherwise rd_ptr++ and go to FETCH.
- Reader does not depend on enable; a stored frame is always delivered.
- Banks are read strictly alternately starting with bank 0, matching fill order.
- Latency: the edge E that writes the last sample sets full. IDLE->FETCH occurs at E+1, and out_valid=1 after E+2. Throughput is 1 sample per 2 cycles (well above the 1 per 250 cycles input rate).
- Simultaneous events:
  - Writer completing a bank in the same cycle as the reader releasing the other bank: no overflow; writer continues in FILL.
  - clr_ovf in the same cycle as a drop: overflow stays 1 (set wins).
- Reset mid-frame: all flags are cleared immediately; any in-flight out_valid drops asynchronously.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, overflow, frame_count and wr_bank read 0 immediately (no clock edge needed); after release, the first frame lands in bank 0.
2. Single frame, FRAME_LEN=8, out_ready=1: write 0x1000..0x1007 -> out_valid rises 2 cycles after the last write; outputs 0x1000..0x1007 with out_index 0..7, one every 2 cycles; out_last only with 0x1007; frame_count=1; wr_bank=1.
3. Backpressure: out_ready=0 for 5 cycles while 0x1003 is presented -> out_data=0x1003, out_index=3 and out_valid=1 hold for all 5 cycles; sample order is unchanged after release.
4. Overflow: out_ready=0, write 3 frames of 8 -> frames 1 and 2 stored; frame 3 samples dropped; overflow=1. Then out_ready=1 -> frame 1 then frame 2 delivered intact; the next sample after bank 0 release is written at index 0. clr_ovf -> overflow=0.
5. Coincident release and fill: time the bank 1 last write in the same cycle as the bank 0 out_last transfer -> overflow stays 0; wr_bank=0 and writing continues.
6. enable low after 3 samples of a frame, then high -> the partial frame is discarded; the next 8 samples form a complete frame starting at index 0.
